// File: rtl/csr_file_pkg.sv
// Shared CSR address map, bit positions and constants for the machine-mode CSR file.
package csr_file_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 64;

  typedef enum logic [11:0] {
    CSR_MSTATUS   = 12'h300,
    CSR_MISA      = 12'h301,
    CSR_MIE       = 12'h304,
    CSR_MTVEC     = 12'h305,
    CSR_MSCRATCH  = 12'h340,
    CSR_MEPC      = 12'h341,
    CSR_MCAUSE    = 12'h342,
    CSR_MTVAL     = 12'h343,
    CSR_MIP       = 12'h344,
    CSR_MCYCLE    = 12'hB00,
    CSR_MINSTRET  = 12'hB02,
    CSR_MCYCLEH   = 12'hB80,
    CSR_MINSTRETH = 12'hB82,
    CSR_CYCLE     = 12'hC00,
    CSR_INSTRET   = 12'hC02,
    CSR_CYCLEH    = 12'hC80,
    CSR_INSTRETH  = 12'hC82,
    CSR_MHARTID   = 12'hF14
  } csr_addr_e;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MIE_MTIE     = 7;
  localparam int unsigned MIP_MTIP     = 7;

  localparam logic [XLEN-1:0] MISA_VALUE = 32'h4000_0100;

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit free-running counter with 32-bit half loads that take priority over the increment.
module csr_counter64
  import csr_file_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [XLEN-1:0]  wdata,
  output logic [CNT_W-1:0] value
);

  // A half load keeps the other half at its pre-increment value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) value[XLEN-1:0]     <= wdata;
      if (wr_hi) value[CNT_W-1:XLEN] <= wdata;
    end else if (inc) begin
      value <= value + CNT_W'(1);
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read port, registered writes, counters, trap/mret state.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_addr,
  input  logic            csr_re,
  input  logic            csr_we,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            retire,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret,
  input  logic            irq_timer,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            irq_pending
);

  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic            mie_mtie;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] mie_rd;
  logic [XLEN-1:0] mip_rd;
  logic [XLEN-1:0] rdata_c;
  logic            impl_c;
  logic            wr_en;

  always_comb begin
    mstatus_rd               = '0;
    mstatus_rd[12:11]        = 2'b11;
    mstatus_rd[MSTATUS_MIE]  = mstatus_mie;
    mstatus_rd[MSTATUS_MPIE] = mstatus_mpie;
    mie_rd                   = '0;
    mie_rd[MIE_MTIE]         = mie_mtie;
    mip_rd                   = '0;
    mip_rd[MIP_MTIP]         = irq_timer;
  end

  // Address decode and read mux; impl_c flags a known address.
  always_comb begin
    rdata_c = '0;
    impl_c  = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:                rdata_c = mstatus_rd;
      CSR_MISA:                   rdata_c = MISA_VALUE;
      CSR_MIE:                    rdata_c = mie_rd;
      CSR_MTVEC:                  rdata_c = mtvec_q;
      CSR_MSCRATCH:               rdata_c = mscratch_q;
      CSR_MEPC:                   rdata_c = mepc_q;
      CSR_MCAUSE:                 rdata_c = mcause_q;
      CSR_MTVAL:                  rdata_c = mtval_q;
      CSR_MIP:                    rdata_c = mip_rd;
      CSR_MCYCLE,    CSR_CYCLE:   rdata_c = cycle_cnt[XLEN-1:0];
      CSR_MCYCLEH,   CSR_CYCLEH:  rdata_c = cycle_cnt[CNT_W-1:XLEN];
      CSR_MINSTRET,  CSR_INSTRET: rdata_c = instret_cnt[XLEN-1:0];
      CSR_MINSTRETH, CSR_INSTRETH: rdata_c = instret_cnt[CNT_W-1:XLEN];
      CSR_MHARTID:                rdata_c = '0;
      default:                    impl_c  = 1'b0;
    endcase
  end

  assign csr_illegal = (csr_re | csr_we) &
                       (~impl_c | (csr_we & (csr_addr[11:10] == 2'b11)));
  assign csr_rdata   = csr_illegal ? '0 : rdata_c;
  assign wr_en       = csr_we & ~csr_illegal & ~trap & ~mret;

  // Trap beats mret beats a port write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mtvec_q      <= {RESET_MTVEC[31:2], 2'b00};
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else if (trap) begin
      mepc_q       <= {trap_pc[31:2], 2'b00};
      mcause_q     <= trap_cause;
      mtval_q      <= trap_tval;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie  <= csr_wdata[MSTATUS_MIE];
          mstatus_mpie <= csr_wdata[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_mtie   <= csr_wdata[MIE_MTIE];
        CSR_MTVEC:    mtvec_q    <= {csr_wdata[31:2], 2'b00};
        CSR_MSCRATCH: mscratch_q <= csr_wdata;
        CSR_MEPC:     mepc_q     <= {csr_wdata[31:2], 2'b00};
        CSR_MCAUSE:   mcause_q   <= csr_wdata;
        CSR_MTVAL:    mtval_q    <= csr_wdata;
        default: ;
      endcase
    end
  end

  csr_counter64 u_cycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (wr_en & (csr_addr == CSR_MCYCLE)),
    .wr_hi (wr_en & (csr_addr == CSR_MCYCLEH)),
    .wdata (csr_wdata),
    .value (cycle_cnt)
  );

  csr_counter64 u_instret (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .wr_lo (wr_en & (csr_addr == CSR_MINSTRET)),
    .wr_hi (wr_en & (csr_addr == CSR_MINSTRETH)),
    .wdata (csr_wdata),
    .value (instret_cnt)
  );

  assign mtvec_o     = mtvec_q;
  assign mepc_o      = mepc_q;
  assign irq_pending = mstatus_mie & mie_mtie & irq_timer;

endmodule
